astropix_spi_responder: RTL



---
 rtl/astropix_spi_responder_pkg.sv | 13 +
 rtl/astropix_spi_responder_if.sv | 32 +++
 rtl/astropix_spi_responder_sync_ff.sv | 24 ++
 rtl/astropix_spi_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/astropix_spi_responder_pkg.sv
// rtl/astropix_spi_responder_pkg.sv - shared types and constants for the AstroPix SPI responder
package astropix_spi_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] IDLE_BYTE      = 8'hBC;
    localparam int         WORD_W         = 16;
    localparam int         PAIRS_PER_WORD = 8;

endpackage

// File: rtl/astropix_spi_responder_if.sv
// rtl/astropix_spi_responder_if.sv - chip-side SPI pins plus local hit-word and config-byte streams
interface astropix_spi_responder_if;
    import astropix_spi_pkg::*;

    logic              spi_csb;
    logic              spi_clock;
    logic              spi_mosi;
    logic              spi_miso0;
    logic              spi_miso1;
    logic              interrupt;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_frame_end;
    logic              tx_underrun;
    logic [15:0]       rx_byte_count;

    modport slave (
        input  spi_csb, spi_clock, spi_mosi, tx_data, tx_valid,
        output spi_miso0, spi_miso1, interrupt, tx_ready, rx_data, rx_valid,
               rx_frame_end, tx_underrun, rx_byte_count
    );

    modport master (
        output spi_csb, spi_clock, spi_mosi, tx_data, tx_valid,
        input  spi_miso0, spi_miso1, interrupt, tx_ready, rx_data, rx_valid,
               rx_frame_end, tx_underrun, rx_byte_count
    );

endinterface

// File: rtl/astropix_spi_responder_sync_ff.sv
// rtl/astropix_spi_responder_sync_ff.sv - multi-stage synchronizer with selectable reset value
module sync_ff #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{INIT}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/astropix_spi_responder.sv
// rtl/astropix_spi_responder.sv - oversampling AstroPix 2 SPI chip emulator
// Receives MOSI config bytes and returns one 16-bit hit word per byte, two bits per SCLK.
module astropix_spi_responder
    import astropix_spi_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD   = {IDLE_BYTE, IDLE_BYTE},
    parameter int                SYNC_STAGES = 2
) (
    input logic                      clock,
    input logic                      reset,
    astropix_spi_responder_if.slave  bus
);

    localparam int                CNT_W     = $clog2(PAIRS_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_PAIR = CNT_W'(PAIRS_PER_WORD - 1);

    logic csb_s, sclk_s, mosi_s;
    logic csb_d, sclk_d;

    sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_csb (
        .clock(clock), .reset(reset), .d(bus.spi_csb), .q(csb_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .d(bus.spi_clock), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .d(bus.spi_mosi), .q(mosi_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csb_d  <= 1'b1;
            sclk_d <= 1'b0;
        end else begin
            csb_d  <= csb_s;
            sclk_d <= sclk_s;
        end
    end

    logic sclk_rise, sclk_fall, csb_fall, csb_rise;
    assign sclk_rise = ~csb_s &  sclk_s & ~sclk_d;
    assign sclk_fall = ~csb_s & ~sclk_s &  sclk_d;
    assign csb_fall  =  csb_d & ~csb_s;
    assign csb_rise  = ~csb_d &  csb_s;

    state_t            state, state_next;
    logic              frame_start, frame_stop, load_word, shift_pair, sample_bit;
    logic [CNT_W-1:0]  bit_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // csb deassertion takes priority over any SCLK edge seen in the same cycle
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        load_word   = 1'b0;
        shift_pair  = 1'b0;
        sample_bit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (csb_fall) begin
                    state_next  = S_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (csb_rise) begin
                    state_next = S_IDLE;
                    frame_stop = 1'b1;
                end else if (sclk_rise) begin
                    if (bit_cnt == '0) begin
                        load_word = 1'b1;
                    end else begin
                        shift_pair = 1'b1;
                    end
                end else if (sclk_fall) begin
                    sample_bit = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    logic              take_word;
    logic [WORD_W-1:0] load_value;
    assign take_word  = load_word & bus.tx_valid;
    assign load_value = take_word ? bus.tx_data : IDLE_WORD;

    logic [WORD_W-1:0] tx_shift;
    logic [6:0]        rx_shift;
    logic              miso0_r, miso1_r, rx_valid_r, frame_end_r, underrun_r, interrupt_r;
    logic [7:0]        rx_data_r;
    logic [15:0]       byte_count_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            miso0_r      <= 1'b0;
            miso1_r      <= 1'b0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            frame_end_r  <= 1'b0;
            underrun_r   <= 1'b0;
            interrupt_r  <= 1'b0;
            byte_count_r <= '0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_end_r <= 1'b0;
            underrun_r  <= 1'b0;
            interrupt_r <= bus.tx_valid & csb_s;
            if (frame_start) begin
                bit_cnt      <= '0;
                tx_shift     <= '0;
                rx_shift     <= '0;
                byte_count_r <= '0;
                miso0_r      <= 1'b0;
                miso1_r      <= 1'b0;
            end
            if (frame_stop) begin
                miso0_r     <= 1'b0;
                miso1_r     <= 1'b0;
                frame_end_r <= 1'b1;
            end
            if (load_word) begin
                {miso0_r, miso1_r} <= load_value[WORD_W-1 -: 2];
                tx_shift           <= {load_value[WORD_W-3:0], 2'b00};
                underrun_r         <= ~bus.tx_valid;
            end
            if (shift_pair) begin
                {miso0_r, miso1_r} <= tx_shift[WORD_W-1 -: 2];
                tx_shift           <= {tx_shift[WORD_W-3:0], 2'b00};
            end
            if (sample_bit) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (bit_cnt == LAST_PAIR) begin
                    rx_data_r  <= {rx_shift, mosi_s};
                    rx_valid_r <= 1'b1;
                    if (byte_count_r != 16'hFFFF) begin
                        byte_count_r <= byte_count_r + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.spi_miso0     = miso0_r;
    assign bus.spi_miso1     = miso1_r;
    assign bus.tx_ready      = take_word;
    assign bus.tx_underrun   = underrun_r;
    assign bus.rx_data       = rx_data_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.rx_frame_end  = frame_end_r;
    assign bus.rx_byte_count = byte_count_r;
    assign bus.interrupt     = interrupt_r;

endmodule
